mm_seq_ctrl: RTL and testbench

- Sequencer that drives the pipelined N-lane multiply/add-tree dot-product unit through a full N x N matrix product, one dot product per cycle.
- Issues row/column indices to external A-row and B-column buffers and forwards the returned vectors to the tree inputs.
- Tracks the tree's fixed pipeline latency so each tree output is tagged with its (row, col) destination and marked valid.
- Sits between the matrix buffers and the result store in the matrix-multiply datapath.

---
 rtl/mm_seq_ctrl.sv | 136 +++++++++++++
 tb/tb_mm_seq_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mm_seq_ctrl.sv
// Sequencer for the N-lane multiply/add-tree: issues an N x N product row-major,
// one dot product per cycle, and tags each tree result with its (row, col).

module mm_seq_lane #(
  parameter int BIT_WIDTH = 8
) (
  input  logic                 en,
  input  logic [BIT_WIDTH-1:0] a_in,
  input  logic [BIT_WIDTH-1:0] b_in,
  output logic [BIT_WIDTH-1:0] a_out,
  output logic [BIT_WIDTH-1:0] b_out
);
  assign a_out = en ? a_in : '0;
  assign b_out = en ? b_in : '0;
endmodule

module mm_seq_ctrl #(
  parameter int BIT_WIDTH = 8,
  parameter int N         = 4,
  parameter int LAT       = 3,
  parameter int IDX_W     = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic [IDX_W-1:0]       a_row_idx,
  output logic [IDX_W-1:0]       b_col_idx,
  output logic                   issue_valid,
  input  logic [BIT_WIDTH*N-1:0] a_row,
  input  logic [BIT_WIDTH*N-1:0] b_col,
  output logic [BIT_WIDTH*N-1:0] tree_a,
  output logic [BIT_WIDTH*N-1:0] tree_b,
  input  logic [BIT_WIDTH-1:0]   tree_c,
  output logic                   res_valid,
  output logic [IDX_W-1:0]       res_row,
  output logic [IDX_W-1:0]       res_col,
  output logic [BIT_WIDTH-1:0]   res_data
);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  typedef struct packed {
    logic [IDX_W-1:0] row;
    logic [IDX_W-1:0] col;
  } tag_t;

  state_t state, state_nxt;
  logic [IDX_W-1:0] row, col;
  logic             last_issue;

  logic [LAT:1] vld_pipe;
  tag_t [LAT:1] tag_pipe;
  tag_t         cur_tag;

  logic [N-1:0][BIT_WIDTH-1:0] a_lanes, b_lanes, ta_lanes, tb_lanes;

  assign last_issue = issue_valid && (row == IDX_W'(N-1)) && (col == IDX_W'(N-1));

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ISSUE;
      ISSUE:   if (last_issue) state_nxt = DRAIN;
      // Last result sits in the final stage this cycle; nothing behind it.
      DRAIN:   if (~|vld_pipe[LAT-1:1]) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    issue_valid = (state == ISSUE);
    busy        = (state == ISSUE) || (state == DRAIN);
    done        = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      row <= '0;
      col <= '0;
    end else if (state == IDLE && start) begin
      row <= '0;
      col <= '0;
    end else if (issue_valid) begin
      if (col == IDX_W'(N-1)) begin
        col <= '0;
        row <= row + IDX_W'(1);
      end else begin
        col <= col + IDX_W'(1);
      end
    end
  end

  assign a_row_idx   = row;
  assign b_col_idx   = col;
  assign cur_tag.row = row;
  assign cur_tag.col = col;

  // Tag pipeline mirrors the tree latency; the tree never stalls, so neither does this.
  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_pipe <= '0;
      tag_pipe <= '0;
    end else begin
      vld_pipe <= {vld_pipe[LAT-1:1], issue_valid};
      tag_pipe <= {tag_pipe[LAT-1:1], cur_tag};
    end
  end

  assign res_valid = vld_pipe[LAT];
  assign res_row   = tag_pipe[LAT].row;
  assign res_col   = tag_pipe[LAT].col;
  assign res_data  = tree_c;

  assign a_lanes = a_row;
  assign b_lanes = b_col;

  for (genvar m = 0; m < N; m++) begin : g_lane
    mm_seq_lane #(.BIT_WIDTH(BIT_WIDTH)) u_lane (
      .en    (issue_valid),
      .a_in  (a_lanes[m]),
      .b_in  (b_lanes[m]),
      .a_out (ta_lanes[m]),
      .b_out (tb_lanes[m])
    );
  end

  assign tree_a = ta_lanes;
  assign tree_b = tb_lanes;
endmodule

// File: tb/tb_mm_seq_ctrl.sv
// Directed bench for mm_seq_ctrl: behavioural buffers and a LAT-deep tree model,
// a table of product runs with hand-computed results, plus reset corner cases.

module tb_mm_seq_ctrl;
  localparam int BW  = 8;
  localparam int N   = 4;
  localparam int LAT = 3;
  localparam int IW  = 2;

  logic            clk = 1'b0;
  logic            rst, start;
  logic            busy, done, issue_valid, res_valid;
  logic [IW-1:0]   a_row_idx, b_col_idx, res_row, res_col;
  logic [BW*N-1:0] a_row, b_col, tree_a, tree_b;
  logic [BW-1:0]   tree_c, res_data;

  mm_seq_ctrl #(.BIT_WIDTH(BW), .N(N), .LAT(LAT), .IDX_W(IW)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .a_row_idx(a_row_idx), .b_col_idx(b_col_idx), .issue_valid(issue_valid),
    .a_row(a_row), .b_col(b_col), .tree_a(tree_a), .tree_b(tree_b),
    .tree_c(tree_c), .res_valid(res_valid), .res_row(res_row),
    .res_col(res_col), .res_data(res_data)
  );

  always #5 clk = ~clk;

  logic [BW-1:0] amem [N][N];
  logic [BW-1:0] bmem [N][N];

  always_comb begin
    a_row = '0;
    b_col = '0;
    for (int m = 0; m < N; m++) begin
      a_row[m*BW +: BW] = amem[a_row_idx][m];
      b_col[m*BW +: BW] = bmem[m][b_col_idx];
    end
  end

  // Tree model: truncating dot product, LAT cycles deep, no reset.
  logic [BW-1:0] dot;
  logic [BW-1:0] tpipe [LAT];
  always_comb begin
    dot = '0;
    for (int m = 0; m < N; m++)
      dot = dot + tree_a[m*BW +: BW] * tree_b[m*BW +: BW];
  end
  always @(posedge clk) begin
    tpipe[0] <= dot;
    for (int i = 1; i < LAT; i++) tpipe[i] <= tpipe[i-1];
  end
  assign tree_c = tpipe[LAT-1];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    string         name;
    int            a_kind;  // 0: constant a_val, 1: identity
    logic [BW-1:0] a_val;
    int            b_kind;  // 0: constant b_val, 1: B[r][c] = 4r+c
    logic [BW-1:0] b_val;
    bit            repulse;
    logic [BW-1:0] exp [16];
  } vec_t;

  vec_t vecs [5];

  task automatic load(input int vi);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        amem[r][c] = (vecs[vi].a_kind == 1) ? BW'(r == c) : vecs[vi].a_val;
        bmem[r][c] = (vecs[vi].b_kind == 1) ? BW'(4*r + c) : vecs[vi].b_val;
      end
  endtask

  // Start is sampled at edge 0; loop covers cycles 1..20, so a following
  // run's start lands in cycle 21.
  task automatic run_vec(input int vi);
    string nm;
    load(vi);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      start = vecs[vi].repulse && (cyc == 5 || cyc == 20);
      nm = $sformatf("%s c%0d", vecs[vi].name, cyc);
      chk({nm, " busy"},  busy,        32'(cyc <= 19));
      chk({nm, " issue"}, issue_valid, 32'(cyc <= 16));
      chk({nm, " done"},  done,        32'(cyc == 20));
      chk({nm, " rvld"},  res_valid,   32'(cyc >= 4 && cyc <= 19));
      if (cyc <= 16) begin
        chk({nm, " arow"}, a_row_idx, 32'((cyc-1) / 4));
        chk({nm, " bcol"}, b_col_idx, 32'((cyc-1) % 4));
        chk({nm, " treea"}, tree_a, a_row);
      end else begin
        chk({nm, " treea0"}, tree_a, 0);
        chk({nm, " treeb0"}, tree_b, 0);
      end
      if (cyc >= 4 && cyc <= 19) begin
        chk({nm, " rrow"}, res_row,  32'((cyc-4) / 4));
        chk({nm, " rcol"}, res_col,  32'((cyc-4) % 4));
        chk({nm, " data"}, res_data, 32'(vecs[vi].exp[cyc-4]));
      end
      tick();
    end
    start = 1'b0;
  endtask

  initial begin
    vecs[0].name = "ones_twos"; vecs[0].a_kind = 0; vecs[0].a_val = 8'd1;
    vecs[0].b_kind = 0; vecs[0].b_val = 8'd2; vecs[0].repulse = 1'b0;
    vecs[1].name = "ident"; vecs[1].a_kind = 1; vecs[1].a_val = 8'd0;
    vecs[1].b_kind = 1; vecs[1].b_val = 8'd0; vecs[1].repulse = 1'b0;
    vecs[2].name = "trunc16"; vecs[2].a_kind = 0; vecs[2].a_val = 8'd16;
    vecs[2].b_kind = 0; vecs[2].b_val = 8'd16; vecs[2].repulse = 1'b0;
    vecs[3].name = "repulse"; vecs[3].a_kind = 0; vecs[3].a_val = 8'd3;
    vecs[3].b_kind = 0; vecs[3].b_val = 8'h55; vecs[3].repulse = 1'b1;
    vecs[4].name = "second"; vecs[4].a_kind = 1; vecs[4].a_val = 8'd0;
    vecs[4].b_kind = 1; vecs[4].b_val = 8'd0; vecs[4].repulse = 1'b0;
    for (int i = 0; i < 16; i++) begin
      vecs[0].exp[i] = 8'd8;          // 4 * (1*2)
      vecs[1].exp[i] = 8'(i);         // I * B = B, row-major order = 4r+c
      vecs[2].exp[i] = 8'd0;          // 4 * 256 mod 256
      vecs[3].exp[i] = 8'hFC;         // 4 * 255 = 1020 mod 256
      vecs[4].exp[i] = 8'(i);
    end

    rst = 1'b0;
    start = 1'b0;
    load(0);
    tick();
    tick();
    chk("rst busy",  busy, 0);
    chk("rst done",  done, 0);
    chk("rst issue", issue_valid, 0);
    chk("rst rvld",  res_valid, 0);
    chk("rst arow",  a_row_idx, 0);
    chk("rst bcol",  b_col_idx, 0);
    chk("rst rrow",  res_row, 0);
    chk("rst rcol",  res_col, 0);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("idle%0d busy", i),  busy, 0);
      chk($sformatf("idle%0d issue", i), issue_valid, 0);
      chk($sformatf("idle%0d rvld", i),  res_valid, 0);
      chk($sformatf("idle%0d done", i),  done, 0);
      tick();
    end

    for (int vi = 0; vi < 5; vi++) run_vec(vi);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("post%0d busy", i), busy, 0);
      chk($sformatf("post%0d done", i), done, 0);
      tick();
    end

    // Reset in cycle 8 of a run while the tree still holds products.
    load(0);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int cyc = 1; cyc < 8; cyc++) tick();
    chk("pre-rst rvld", res_valid, 1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("midrst%0d busy", i),  busy, 0);
      chk($sformatf("midrst%0d rvld", i),  res_valid, 0);
      chk($sformatf("midrst%0d issue", i), issue_valid, 0);
      chk($sformatf("midrst%0d done", i),  done, 0);
      tick();
    end
    run_vec(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
